idecoder_queue: RTL

- Registered, flow-controlled successor to the combinational instruction decoder.
- Accepts raw RV32I instruction words plus PC from fetch over a valid/ready handshake, decodes them, and buffers decoded records in a DEPTH-entry FIFO feeding the execute stage.
- Adds three things the combinational decoder lacks: illegal-instruction detection, fields that are defined as zero when unused, and a pipeline flush.

---
 rtl/idecoder_queue.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/idecoder_queue.sv
// RV32I decoder with illegal-instruction detection feeding a DEPTH-entry
// decoded-record FIFO; valid/ready on both sides plus a synchronous flush.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IMM_WIDTH
`define IMM_WIDTH 32
`endif
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 5
`endif

module idecoder_queue #(
    parameter int PC_WIDTH      = 32,
    parameter int DEPTH         = 2,
    parameter int ILL_CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        inst_valid,
    output logic                        inst_ready,
    input  logic [`INST_WIDTH-1:0]      inst,
    input  logic [PC_WIDTH-1:0]         inst_pc,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [PC_WIDTH-1:0]         dec_pc,
    output logic [`IMM_WIDTH-1:0]       imm,
    output logic [`INST_TYPE_WIDTH-1:0] inst_type,
    output logic [`REG_WIDTH-1:0]       rd,
    output logic [`REG_WIDTH-1:0]       rs1,
    output logic [`REG_WIDTH-1:0]       rs2,
    output logic [`FUNCT_WIDTH-1:0]     funct,
    output logic                        illegal,
    output logic [ILL_CNT_WIDTH-1:0]    ill_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam int REC_W = PC_WIDTH + `IMM_WIDTH + `INST_TYPE_WIDTH
                         + 3 * `REG_WIDTH + `FUNCT_WIDTH + 1;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_INT_IMM = 7'b0010011;
    localparam logic [6:0] OP_INT_REG = 7'b0110011;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;

    // Type 0 doubles as the "no instruction / illegal" class.
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_LUI     = 4'd1;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_AUIPC   = 4'd2;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_JAL     = 4'd3;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_JALR    = 4'd4;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_BRANCH  = 4'd5;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_LOAD    = 4'd6;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_STORE   = 4'd7;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_INT_IMM = 4'd8;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_INT_REG = 4'd9;
    localparam logic [`INST_TYPE_WIDTH-1:0] TYPE_FENCE   = 4'd10;

    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_ADD      = 5'd1;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_SUB      = 5'd2;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_SLL      = 5'd3;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_SLT      = 5'd4;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_SLTU     = 5'd5;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_XOR      = 5'd6;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_SRL      = 5'd7;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_SRA      = 5'd8;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_OR       = 5'd9;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_AND      = 5'd10;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_BEQ      = 5'd11;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_BNE      = 5'd12;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_BLT      = 5'd13;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_BGE      = 5'd14;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_BLTU     = 5'd15;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_BGEU     = 5'd16;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_MEM_BYTE = 5'd17;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_MEM_HALF = 5'd18;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_MEM_WORD = 5'd19;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_MEM_BU   = 5'd20;
    localparam logic [`FUNCT_WIDTH-1:0] FUNCT_MEM_HU   = 5'd21;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    logic [`IMM_WIDTH-1:0]       d_imm;
    logic [`INST_TYPE_WIDTH-1:0] d_type;
    logic [`REG_WIDTH-1:0]       d_rd, d_rs1, d_rs2;
    logic [`FUNCT_WIDTH-1:0]     d_funct;
    logic                        d_ill;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'h000};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign shamt  = {27'd0, inst[24:20]};

    always_comb begin
        d_type  = '0;
        d_imm   = '0;
        d_rd    = '0;
        d_rs1   = '0;
        d_rs2   = '0;
        d_funct = '0;
        d_ill   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                d_type = (opcode == OP_LUI) ? TYPE_LUI : TYPE_AUIPC;
                d_imm  = imm_u;
                d_rd   = inst[11:7];
            end
            OP_JAL: begin
                d_type = TYPE_JAL;
                d_imm  = imm_j;
                d_rd   = inst[11:7];
            end
            OP_JALR: begin
                d_type  = TYPE_JALR;
                d_imm   = imm_i;
                d_rd    = inst[11:7];
                d_rs1   = inst[19:15];
                d_funct = FUNCT_ADD;
                d_ill   = (f3 != 3'd0);
            end
            OP_BRANCH: begin
                d_type = TYPE_BRANCH;
                d_imm  = imm_b;
                d_rs1  = inst[19:15];
                d_rs2  = inst[24:20];
                case (f3)
                    3'd0:    d_funct = FUNCT_BEQ;
                    3'd1:    d_funct = FUNCT_BNE;
                    3'd4:    d_funct = FUNCT_BLT;
                    3'd5:    d_funct = FUNCT_BGE;
                    3'd6:    d_funct = FUNCT_BLTU;
                    3'd7:    d_funct = FUNCT_BGEU;
                    default: d_ill   = 1'b1;
                endcase
            end
            OP_LOAD: begin
                d_type = TYPE_LOAD;
                d_imm  = imm_i;
                d_rd   = inst[11:7];
                d_rs1  = inst[19:15];
                case (f3)
                    3'd0:    d_funct = FUNCT_MEM_BYTE;
                    3'd1:    d_funct = FUNCT_MEM_HALF;
                    3'd2:    d_funct = FUNCT_MEM_WORD;
                    3'd4:    d_funct = FUNCT_MEM_BU;
                    3'd5:    d_funct = FUNCT_MEM_HU;
                    default: d_ill   = 1'b1;
                endcase
            end
            OP_STORE: begin
                d_type = TYPE_STORE;
                d_imm  = imm_s;
                d_rs1  = inst[19:15];
                d_rs2  = inst[24:20];
                case (f3)
                    3'd0:    d_funct = FUNCT_MEM_BYTE;
                    3'd1:    d_funct = FUNCT_MEM_HALF;
                    3'd2:    d_funct = FUNCT_MEM_WORD;
                    default: d_ill   = 1'b1;
                endcase
            end
            OP_INT_IMM: begin
                d_type = TYPE_INT_IMM;
                d_imm  = imm_i;
                d_rd   = inst[11:7];
                d_rs1  = inst[19:15];
                case (f3)
                    3'd0: d_funct = FUNCT_ADD;
                    3'd1: begin
                        d_funct = FUNCT_SLL;
                        d_imm   = shamt;
                        d_ill   = (f7 != 7'd0);
                    end
                    3'd2: d_funct = FUNCT_SLT;
                    3'd3: d_funct = FUNCT_SLTU;
                    3'd4: d_funct = FUNCT_XOR;
                    3'd5: begin
                        d_imm = shamt;
                        if (f7 == 7'd0)       d_funct = FUNCT_SRL;
                        else if (f7 == 7'd32) d_funct = FUNCT_SRA;
                        else                  d_ill   = 1'b1;
                    end
                    3'd6:    d_funct = FUNCT_OR;
                    default: d_funct = FUNCT_AND;
                endcase
            end
            OP_INT_REG: begin
                d_type = TYPE_INT_REG;
                d_rd   = inst[11:7];
                d_rs1  = inst[19:15];
                d_rs2  = inst[24:20];
                if (f7 == 7'd0) begin
                    case (f3)
                        3'd0:    d_funct = FUNCT_ADD;
                        3'd1:    d_funct = FUNCT_SLL;
                        3'd2:    d_funct = FUNCT_SLT;
                        3'd3:    d_funct = FUNCT_SLTU;
                        3'd4:    d_funct = FUNCT_XOR;
                        3'd5:    d_funct = FUNCT_SRL;
                        3'd6:    d_funct = FUNCT_OR;
                        default: d_funct = FUNCT_AND;
                    endcase
                end else if (f7 == 7'd32 && f3 == 3'd0) begin
                    d_funct = FUNCT_SUB;
                end else if (f7 == 7'd32 && f3 == 3'd5) begin
                    d_funct = FUNCT_SRA;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OP_FENCE: d_type = TYPE_FENCE;
            default:  d_ill  = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) d_ill = 1'b1;
        // Illegal records carry only the flag and the PC.
        if (d_ill) begin
            d_type  = '0;
            d_imm   = '0;
            d_rd    = '0;
            d_rs1   = '0;
            d_rs2   = '0;
            d_funct = '0;
        end
    end

    logic [REC_W-1:0] mem [DEPTH];
    logic [REC_W-1:0] head_rec;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    assign inst_ready = (count != FULL) && !flush;
    assign dec_valid  = (count != '0);
    assign push       = inst_valid && inst_ready;
    assign pop        = dec_valid && dec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ill_count <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            if (push && d_ill && (ill_count != '1)) ill_count <= ill_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {inst_pc, d_imm, d_type, d_rd, d_rs1, d_rs2, d_funct, d_ill};
    end

    assign head_rec = dec_valid ? mem[rd_ptr] : '0;
    assign {dec_pc, imm, inst_type, rd, rs1, rs2, funct, illegal} = head_rec;

endmodule
